// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types and helpers for the BCD timer controller.
// Holds the FSM state enum, the BCD digit type and the digit validity check.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade (0..9) counter of the BCD chain.
// Ports: clk, reset (sync, active-low), en (advance), clr, ld/ld_val (preset),
// q (digit value), carry (en & q==9, enables the next digit).
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t q,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

  assign carry = en & (q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: start/pause/clear/preset sequencer for a DIGITS-long BCD
// count chain that stops (or reloads) on a latched target and pulses done.
// Ports: clk, reset (sync, active-low), tick, start, stop, clr, load,
// load_val, target (BCD inputs); count, busy, done, err (outputs).
// Build option: define BCD_TIMER_AUTORELOAD_EN to restart from 0 on match.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   target_q;
  logic [W-1:0]   inc_val;
  bcd_digit_t     q [DIGITS];
  logic [DIGITS:0] en_c;
  logic [DIGITS:0] inc_c;

  logic cnt_en;
  logic dig_clr;
  logic dig_ld;
  logic tgt_ld;
  logic err_set;
  logic err_clr;
  logic done_nxt;
  logic tgt_ok;
  logic ld_ok;
  logic tgt_zero;
  logic match;
  logic unused;

  assign en_c[0]  = cnt_en;
  assign inc_c[0] = 1'b1;

  // inc_val is the would-be next count, built independently of the
  // digit enables so the match test does not loop through cnt_en.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk    (clk),
      .reset  (reset),
      .en     (en_c[i]),
      .clr    (dig_clr),
      .ld     (dig_ld),
      .ld_val (load_val[4*i +: 4]),
      .q      (q[i]),
      .carry  (en_c[i+1])
    );

    assign inc_val[4*i +: 4] =
      !inc_c[i]          ? q[i] :
      (q[i] == BCD_MAX)  ? 4'd0 :
                           q[i] + 4'd1;
    assign inc_c[i+1] = inc_c[i] & (q[i] == BCD_MAX);
  end

  assign unused = en_c[DIGITS] ^ inc_c[DIGITS];

  always_comb begin
    tgt_ok = 1'b1;
    ld_ok  = 1'b1;
    count  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      tgt_ok &= bcd_valid(target[4*i +: 4]);
      ld_ok  &= bcd_valid(load_val[4*i +: 4]);
      count[4*i +: 4] = q[i];
    end
  end

  assign tgt_zero = (target == '0);
  assign match    = (inc_val == target_q);

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    dig_clr   = 1'b0;
    dig_ld    = 1'b0;
    tgt_ld    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    done_nxt  = 1'b0;
    if (clr) begin
      dig_clr   = 1'b1;
      err_clr   = 1'b1;
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (load) begin
            if (state == IDLE) begin
              if (ld_ok) dig_ld = 1'b1;
              else       err_set = 1'b1;
            end
          end else if (start) begin
            if (!tgt_ok) begin
              err_set = 1'b1;
            end else begin
              tgt_ld    = 1'b1;
              dig_clr   = 1'b1;
              done_nxt  = tgt_zero;
              state_nxt = tgt_zero ? DONE : RUN;
            end
          end
        end
        RUN: begin
          // load/start outrank stop; both are no-ops while running
          if (stop && !load && !start) begin
            state_nxt = PAUSE;
          end else if (tick) begin
            cnt_en = 1'b1;
            if (match) begin
              done_nxt = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
              dig_clr = 1'b1;
`else
              state_nxt = DONE;
`endif
            end
          end
        end
        PAUSE: begin
          if (load) begin
            if (ld_ok) dig_ld = 1'b1;
            else       err_set = 1'b1;
          end else if (start) begin
            state_nxt = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      target_q <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (tgt_ld) target_q <= target;
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: randomized bench for bcd_timer_ctrl (DIGITS=2) with a
// decimal reference model feeding an expected-output queue.
module tb_bcd_timer_ctrl;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MOD    = 100;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE = 3;
`ifdef BCD_TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tick = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] target = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .target   (target),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_cnt = 0;
  int   m_tq = 0;
  int   m_mode = M_IDLE;
  logic m_done = 1'b0;
  logic m_err = 1'b0;

  function automatic bit is_bcd(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--)
      r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic model(input logic r, t, sa, so, c, l,
                       input logic [W-1:0] lv, tg);
    m_done = 1'b0;
    if (!r) begin
      m_cnt = 0; m_tq = 0; m_mode = M_IDLE; m_err = 1'b0;
    end else if (c) begin
      m_cnt = 0; m_mode = M_IDLE; m_err = 1'b0;
    end else if (m_mode == M_RUN) begin
      if (so && !l && !sa) begin
        m_mode = M_PAUSE;
      end else if (t) begin
        m_cnt = (m_cnt + 1) % MOD;
        if (m_cnt == m_tq) begin
          m_done = 1'b1;
          if (AUTO) m_cnt = 0;
          else      m_mode = M_DONE;
        end
      end
    end else if (l) begin
      if (m_mode != M_DONE) begin
        if (is_bcd(lv)) m_cnt = to_int(lv);
        else            m_err = 1'b1;
      end
    end else if (sa) begin
      if (m_mode == M_PAUSE) begin
        m_mode = M_RUN;
      end else if (!is_bcd(tg)) begin
        m_err = 1'b1;
      end else begin
        m_tq   = to_int(tg);
        m_cnt  = 0;
        m_mode = (m_tq == 0) ? M_DONE : M_RUN;
        m_done = (m_tq == 0);
      end
    end
  endtask

  task automatic drive(input logic r, t, sa, so, c, l,
                       input logic [W-1:0] lv, tg);
    exp_t e;
    @(negedge clk);
    reset = r; tick = t; start = sa; stop = so;
    clr = c; load = l; load_val = lv; target = tg;
    model(r, t, sa, so, c, l, lv, tg);
    e.count = to_bcd(m_cnt);
    e.busy  = (m_mode == M_RUN);
    e.done  = m_done;
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(1, 1, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic go(input logic [W-1:0] tg);
    drive(1, 0, 1, 0, 0, 0, '0, tg);
  endtask

  task automatic cmp(input string name, input logic [W-1:0] act, req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t",
               name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("count", count, e.count);
        cmp("busy", W'(busy), W'(e.busy));
        cmp("done", W'(done), W'(e.done));
        cmp("err", W'(err), W'(e.err));
      end
    end
  end

  initial begin
    logic         r, t, sa, so, c, l;
    logic [W-1:0] lv, tg;
    int           pick;

    drive(0, 1, 0, 0, 0, 0, '0, '0);
    drive(0, 1, 0, 0, 0, 0, '0, '0);

    go(8'h12);
    ticks(14);

    go(8'h12);
    ticks(5);
    drive(1, 1, 0, 1, 0, 0, '0, '0);
    ticks(3);
    go(8'h00);
    ticks(10);

    go(8'h12);
    ticks(2);
    drive(1, 0, 0, 1, 0, 0, '0, '0);
    drive(1, 0, 0, 0, 0, 1, 8'h97, '0);
    go(8'h00);
    ticks(20);

    drive(1, 0, 0, 0, 1, 0, '0, '0);
    go(8'h1A);
    ticks(2);
    drive(1, 0, 0, 0, 1, 0, '0, '0);
    drive(1, 0, 0, 0, 0, 1, 8'hA3, '0);
    drive(1, 0, 0, 0, 1, 0, '0, '0);

    go(8'h12);
    ticks(3);
    drive(1, 1, 1, 0, 1, 0, '0, 8'h12);
    go(8'h12);
    ticks(3);
    drive(0, 1, 0, 0, 0, 0, '0, '0);
    ticks(1);

    go(8'h00);
    ticks(2);
    go(8'h03);
    ticks(10);

    repeat (3000) begin
      r  = ($urandom_range(0, 399) != 0);
      t  = ($urandom_range(0, 9) < 7);
      sa = ($urandom_range(0, 99) < 6);
      so = ($urandom_range(0, 99) < 4);
      c  = ($urandom_range(0, 199) < 2);
      l  = ($urandom_range(0, 99) < 4);
      lv = ($urandom_range(0, 3) != 0) ?
           to_bcd(int'($urandom_range(0, 99))) : W'($urandom);
      pick = int'($urandom_range(0, 3));
      if (pick < 2)       tg = to_bcd(int'($urandom_range(0, 25)));
      else if (pick == 2) tg = to_bcd(int'($urandom_range(0, 99)));
      else                tg = W'($urandom);
      drive(r, t, sa, so, c, l, lv, tg);
    end

    ticks(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
